// File: rtl/seq_bit_serializer.sv
// Parallel-in/serial-out word serializer feeding the 1001 sequence detectors.
// Emits one bit per clk. Back-to-back words produce a gap-free bit stream.
module seq_bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shift_reg, shift_reg_n;
    logic             ser_out_n;
    logic             ser_valid_n;
    logic             frame_start_n;
    logic             frame_end_n;
    logic             accept;
    logic             last_bit;

    // A new word may be taken when idle or while the last bit is on the line.
    assign last_bit = (state == SHIFT) && (bit_cnt == LAST);
    assign in_ready = !rst && ((state == IDLE) || last_bit);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == SHIFT);

    // State, counter, shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            ser_out     <= IDLE_BIT;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift_reg   <= shift_reg_n;
            ser_out     <= ser_out_n;
            ser_valid   <= ser_valid_n;
            frame_start <= frame_start_n;
            frame_end   <= frame_end_n;
        end
    end

    // Next-state logic: load on accept, otherwise shift or fall back to idle.
    // shift_reg keeps the word aligned so the next bit sits one place behind
    // the bit already on ser_out.
    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        shift_reg_n   = shift_reg;
        ser_out_n     = IDLE_BIT;
        ser_valid_n   = 1'b0;
        frame_start_n = 1'b0;
        frame_end_n   = 1'b0;
        if (accept) begin
            state_n       = SHIFT;
            bit_cnt_n     = '0;
            shift_reg_n   = in_data;
            ser_valid_n   = 1'b1;
            frame_start_n = 1'b1;
            if (MSB_FIRST != 0) begin
                ser_out_n = in_data[WIDTH-1];
            end else begin
                ser_out_n = in_data[0];
            end
        end else if ((state == SHIFT) && !last_bit) begin
            bit_cnt_n   = bit_cnt + CNT_W'(1);
            ser_valid_n = 1'b1;
            frame_end_n = (bit_cnt_n == LAST);
            if (MSB_FIRST != 0) begin
                ser_out_n   = shift_reg[WIDTH-2];
                shift_reg_n = {shift_reg[WIDTH-2:0], 1'b0};
            end else begin
                ser_out_n   = shift_reg[1];
                shift_reg_n = {1'b0, shift_reg[WIDTH-1:1]};
            end
        end else if (last_bit) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
        end
    end

endmodule
